// File: rtl/decimal_adjust.sv
// decimal_adjust: two-step BCD correction stage for ADC/SBC in decimal mode.
// It captures the ALU binary result and carry flags. Low-nibble and then
// high-nibble correction run in two internal cycles on a private 8-bit adder.
// The corrected byte and the P flags are presented at DONE.
// Optional build macro DEC_CMOS_FLAGS_EN: N/Z come from the corrected byte
// (65C02). When the macro is undefined, N/Z come from the binary ALU result
// (NMOS).
module decimal_adjust (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sub,
  input  logic [7:0] res,
  input  logic       c8,
  input  logic       v_in,
  input  logic       hc,
  input  logic       dhc,
  input  logic       dc,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       C,
  output logic       N,
  output logic       Z,
  output logic       V
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t     r_state;
  state_t     w_next;

  // Working accumulator and decisions latched at capture.
  logic [7:0] r_acc;
  logic       r_sub;
  logic       r_fix_lo;
  logic       r_fix_hi;
  logic       r_c_lat;
  logic       r_v_lat;
  logic       r_n_lat;
  logic       r_z_lat;

  // Visible result/flags, updated only on HI -> DONE.
  logic [7:0] r_result;
  logic       r_c;
  logic       r_n;
  logic       r_z;
  logic       r_v;

  logic       w_capture;
  logic [7:0] w_lo_acc;
  logic [7:0] w_hi_acc;

  // Low-nibble step: ADC carries into the high nibble, SBC stays inside the nibble.
  function automatic logic [7:0] fix_low(input logic [7:0] acc, input logic is_sub);
    logic [3:0] lo_dec;
    lo_dec = acc[3:0] - 4'd6;
    fix_low = is_sub ? {acc[7:4], lo_dec} : (acc + 8'h06);
  endfunction

  // High-nibble step: plain mod-256 add/subtract of 0x60.
  function automatic logic [7:0] fix_high(input logic [7:0] acc, input logic is_sub);
    fix_high = is_sub ? (acc - 8'h60) : (acc + 8'h60);
  endfunction

  assign w_capture = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_lo_acc  = r_fix_lo ? fix_low(r_acc, r_sub)  : r_acc;
  assign w_hi_acc  = r_fix_hi ? fix_high(r_acc, r_sub) : r_acc;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: fixed three-cycle walk IDLE/DONE -> LO -> HI -> DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_capture ? LO : IDLE;
      LO:      w_next = HI;
      HI:      w_next = DONE;
      DONE:    w_next = w_capture ? LO : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture the ALU result and correction decisions, then apply the low-nibble step.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_acc    <= res;
      r_sub    <= sub;
      r_fix_lo <= sub ? ~hc : (hc | dhc);
      r_fix_hi <= sub ? ~c8 : (c8 | dc);
      r_c_lat  <= sub ? c8  : (c8 | dc);
      r_v_lat  <= v_in;
      r_n_lat  <= res[7];
      r_z_lat  <= (res == 8'h00);
    end else if (r_state == LO) begin
      r_acc    <= w_lo_acc;
    end
  end

  // Publish the corrected byte and flags as the machine enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= 8'h00;
      r_c      <= 1'b0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_v      <= 1'b0;
    end else if (r_state == HI) begin
      r_result <= w_hi_acc;
      r_c      <= r_c_lat;
      r_v      <= r_v_lat;
`ifdef DEC_CMOS_FLAGS_EN
      r_n      <= w_hi_acc[7];
      r_z      <= (w_hi_acc == 8'h00);
`else
      r_n      <= r_n_lat;
      r_z      <= r_z_lat;
`endif
    end
  end

`ifdef DEC_CMOS_FLAGS_EN
  // Binary-result N/Z latches are not needed when flags follow the corrected byte.
  logic w_unused_nz;
  assign w_unused_nz = r_n_lat ^ r_z_lat;
`endif

  assign busy   = (r_state == LO) || (r_state == HI);
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign C      = r_c;
  assign N      = r_n;
  assign Z      = r_z;
  assign V      = r_v;

endmodule

// File: tb/tb_decimal_adjust.sv
// Scoreboard bench for decimal_adjust. Random BCD ADC/SBC operands are run
// through an ALU-flag model, and the expected outcome comes from decimal
// arithmetic. A separate monitor pops the expected outcome on every done.
module tb_decimal_adjust;

  logic       clk = 1'b0;
  logic       reset, start, sub, c8, v_in, hc, dhc, dc;
  logic [7:0] res;
  logic       busy, done, C, N, Z, V;
  logic [7:0] result;

  decimal_adjust dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .res(res), .c8(c8),
    .v_in(v_in), .hc(hc), .dhc(dhc), .dc(dc), .busy(busy), .done(done),
    .result(result), .C(C), .N(N), .Z(Z), .V(V)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic       c, n, z, v;
    int         cap;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  function automatic int to_bcd(input int d);
    return ((d / 10) << 4) | (d % 10);
  endfunction

  // Monitor: runs 2 time units after each edge, away from the active edge.
  always @(posedge clk) begin
    exp_t e;
    logic exp_busy;
    #2;
    if (done) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done at cycle %0d: got done=1, required no done", cyc);
      end else begin
        e = q.pop_front();
        if (cyc != e.cap + 2 || result !== e.r || C !== e.c || N !== e.n ||
            Z !== e.z || V !== e.v) begin
          n_fail++;
          $display("FAIL op_result cap=%0d: got cyc=%0d r=%02h C=%b N=%b Z=%b V=%b, required cyc=%0d r=%02h C=%b N=%b Z=%b V=%b",
                   e.cap, cyc, result, C, N, Z, V, e.cap + 2, e.r, e.c, e.n, e.z, e.v);
        end
      end
    end else if (q.size() > 0 && cyc >= q[0].cap + 2) begin
      e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_done cap=%0d: got done=0 at cycle %0d, required done=1", e.cap, cyc);
    end
    exp_busy = (q.size() > 0) && (cyc < q[0].cap + 2);
    if (busy !== exp_busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL busy at cycle %0d: got %b, required %b", cyc, busy, exp_busy);
    end
  end

  // Drive one capture (called at edge+3); returns at capture edge+3 in LO.
  task automatic issue(input logic s, input logic [7:0] r, input logic c8_i, v_i,
                       hc_i, dhc_i, dc_i, input logic [7:0] er, input logic ec);
    exp_t e;
    start = 1'b1; sub = s; res = r; c8 = c8_i; v_in = v_i;
    hc = hc_i; dhc = dhc_i; dc = dc_i;
    @(posedge clk);
    #1;
    e.r = er; e.c = ec; e.v = v_i; e.cap = cyc;
`ifdef DEC_CMOS_FLAGS_EN
    e.n = er[7]; e.z = (er == 8'h00);
`else
    e.n = r[7];  e.z = (r == 8'h00);
`endif
    q.push_back(e);
    #2;
    start = 1'b0;
    res = 8'($urandom); sub = 1'($urandom); c8 = 1'($urandom); v_in = 1'($urandom);
    hc = 1'($urandom); dhc = 1'($urandom); dc = 1'($urandom);
  endtask

  // Advance from LO to DONE, optionally pulsing start in LO and HI (must be ignored).
  task automatic to_done(input logic noise);
    for (int k = 0; k < 2; k++) begin
      if (noise) begin
        start = 1'b1; res = 8'($urandom); sub = 1'($urandom);
      end
      @(posedge clk);
      #3;
      start = 1'b0;
    end
  endtask

  // ALU-flag model on random BCD operands; expected value from decimal arithmetic.
  task automatic issue_rand();
    int da, db, ci, s, a, b, bin, lo, t, dd, er;
    logic f_hc, f_dhc, f_dc, f_c8, f_v, ec;
    da = $urandom_range(0, 99); db = $urandom_range(0, 99);
    ci = $urandom_range(0, 1);  s  = $urandom_range(0, 1);
    a = to_bcd(da); b = to_bcd(db);
    if (s == 0) begin
      bin   = a + b + ci;
      lo    = (a & 15) + (b & 15) + ci;
      f_hc  = (lo > 15);
      f_dhc = ((bin & 15) > 9);
      t     = (bin & 255) + ((f_hc || f_dhc) ? 6 : 0);
      f_dc  = ((t >> 4) > 9);
      f_c8  = (bin > 255);
      f_v   = ((~(a ^ b)) & (a ^ bin) & 128) != 0;
      dd    = da + db + ci;
      er    = to_bcd(dd % 100);
      ec    = (dd > 99);
    end else begin
      bin   = a - b - (1 - ci);
      f_c8  = (bin >= 0);
      f_hc  = ((a & 15) - (b & 15) - (1 - ci)) >= 0;
      f_dhc = 1'($urandom);
      f_dc  = 1'($urandom);
      f_v   = ((a ^ b) & (a ^ (bin & 255)) & 128) != 0;
      dd    = da - db - (1 - ci);
      ec    = (dd >= 0);
      er    = to_bcd(dd < 0 ? dd + 100 : dd);
    end
    issue(s[0], 8'(bin & 255), f_c8, f_v, f_hc, f_dhc, f_dc, 8'(er), ec);
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if (result !== 8'h00 || C !== 1'b0 || N !== 1'b0 || Z !== 1'b0 ||
        V !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got r=%02h C=%b N=%b Z=%b V=%b busy=%b done=%b, required all zero",
               name, result, C, N, Z, V, busy, done);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; res = 8'h00;
    c8 = 1'b0; v_in = 1'b0; hc = 1'b0; dhc = 1'b0; dc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    #2;
    reset = 1'b0;
    @(posedge clk); #3;

    // Directed cases, run back-to-back (start asserted in DONE).
    issue(1'b0, 8'h9F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 1'b1);  // 58+46+1
    to_done(1'b1);
    issue(1'b0, 8'h9A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);  // 99+01
    to_done(1'b1);
    issue(1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h09, 1'b1);  // 10-01
    to_done(1'b0);
    issue(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0);  // 00-01
    to_done(1'b0);
    @(posedge clk); #3;

    // Random operations: mix of back-to-back, idle gaps and ignored starts.
    for (int i = 0; i < 60; i++) begin
      issue_rand();
      to_done(1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #3;
      end
    end
    @(posedge clk); #3;

    // Reset asserted while in HI aborts the operation.
    issue(1'b0, 8'h9F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 1'b1);
    @(posedge clk); #3;
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    check_zero("reset_in_hi");
    #2;
    reset = 1'b0;
    issue(1'b0, 8'h9A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
    to_done(1'b0);
    repeat (5) @(posedge clk);
    #3;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding ops, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decimal_adjust.md
# decimal_adjust

Sequential BCD correction stage sitting directly downstream of the ALU. For ADC/SBC in decimal mode, the control logic pulses `start` while the ALU presents the binary sum and its carry flags. This block captures that result and applies low-nibble and then high-nibble correction in two internal cycles, using its own 8-bit correction adder so the ALU stays free. It then presents the BCD result and the P-register flag values for write-back.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  capture request; sampled only in IDLE or DONE.
- `sub`  in  1  1 = SBC correction, 0 = ADC correction; captured with `start`.
- `res`  in  8  ALU binary result (ALU OUT).
- `c8`  in  1  ALU carry out.
- `v_in`  in  1  ALU overflow.
- `hc`  in  1  ALU digital half carry (carry out of bit 3).
- `dhc`  in  1  ALU decimal half carry (low nibble > 9).
- `dc`  in  1  ALU decimal carry (high nibble > 9, including the low-nibble correction case).
- `busy`  out  1  high in LO and HI.
- `done`  out  1  one-cycle pulse in DONE.
- `result`  out  8  corrected BCD byte; held until the next capture.
- `C`  out  1  decimal carry/borrow flag.
- `N`  out  1  negative flag.
- `Z`  out  1  zero flag.
- `V`  out  1  overflow flag.

## Operation
- States: IDLE, LO, HI, DONE. Encoding is free.
- IDLE:
  - `start`=1 → latch `res`, `sub`, `v_in`, and the correction decisions; go to LO.
  - Otherwise stay in IDLE.
- Latched decisions:
  - ADC: `fix_lo` = `hc`|`dhc`; `fix_hi` = `c8`|`dc`; C = `c8`|`dc`.
  - SBC: `fix_lo` = !`hc`; `fix_hi` = !`c8`; C = `c8`.
- LO: if `fix_lo`:
  - ADC: acc = acc + 0x06, 8-bit, carry propagates into the high nibble.
  - SBC: acc[3:0] = acc[3:0] − 6 mod 16; acc[7:4] unchanged (no borrow across nibbles).
  - Then go to HI.
- HI: if `fix_hi`:
  - ADC: acc = acc + 0x60 mod 256.
  - SBC: acc = acc − 0x60 mod 256.
  - Then go to DONE.
- DONE:
  - `done`=1 for this cycle only.
  - `start`=1 → capture as in IDLE and go to LO (back-to-back operations).
  - Otherwise go to IDLE.
- `start` in LO or HI is ignored; there is no queueing.
- C is never modified by the correction adds; its value is the latched decision above.
- V always equals the latched `v_in` (binary overflow, NMOS behaviour).
- `result` = acc. `result`/flags update visibly only after HI, at DONE entry. While busy, they hold the previous operation's values.
- Reset: `result`=0x00, C=0, N=0, Z=0, V=0, `busy`=0, `done`=0; state IDLE.
- Reset asserted in any state, including mid-operation, aborts the operation and takes precedence over `start`.

## Timing
- Edge 0: `start` sampled → LO.
- Edge 1: → HI.
- Edge 2: → DONE; `result`/C/N/Z/V valid from this edge.
- `done` high for the cycle between edge 2 and edge 3.
- Latency is 3 cycles from `start` to `done`, with no dependence on data.
- Throughput is one operation per 3 cycles when `start` is asserted in DONE.
- Inputs are sampled only at the capture edge and may change freely afterward.

## Configuration
- `DEC_CMOS_FLAGS_EN` defined: N = `result`[7] and Z = (`result` == 0), both taken from the corrected byte (65C02 behaviour).
- `DEC_CMOS_FLAGS_EN` undefined: N = `res`[7] and Z = (`res` == 0), both taken from the latched binary ALU result (NMOS behaviour).
- C, V, state machine, and latency are identical in both builds.

## Test plan
- ADC 58+46+1: `res`=0x9F, `c8`=0, `hc`=0, `dhc`=1, `dc`=1, `sub`=0 → `result`=0x05, C=1. N=1/Z=0 in the NMOS build; N=0/Z=0 in the CMOS build.
- ADC 99+01: `res`=0x9A, `c8`=0, `hc`=0, `dhc`=1, `dc`=1 → `result`=0x00, C=1. NMOS: Z=0, N=1. CMOS: Z=1, N=0.
- SBC 10−01: `sub`=1, `res`=0x0F, `c8`=1, `hc`=0 → `result`=0x09, C=1.
- SBC 00−01: `sub`=1, `res`=0xFF, `c8`=0, `hc`=0 → `result`=0x99, C=0.
- Back-to-back and busy handling: `start` asserted in DONE is accepted with `done` spacing of exactly 3 cycles. `start` pulses in LO/HI produce no extra `done`.
- Reset asserted in HI: next cycle state IDLE with all outputs 0. A subsequent ADC 0x9A case completes normally, 3 cycles after its `start`.
